// File: rtl/jk_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// jk_cmd_scheduler
//
// Queues hold/reset/set/toggle commands for a bank of N JK flip-flops and
// plays each one out on the registered j/k lines for rep+1 clock edges. A
// one-cycle settle gap lets the bank's last update reach q_in. The DONE cycle
// then shows the captured snapshot on q_snap together with the done pulse.
//
// Optional self-check: define JK_CMD_SCHED_CHECK_EN to compare the bank state
// at completion against the value implied by the command. Any mismatch sets a
// sticky err flag. Without the macro, err is tied low.
//
// Ports
//   clk        clock shared with the JK bank
//   rst        asynchronous, active-high reset
//   cmd_valid  command offered this cycle
//   cmd_ready  FIFO not full; a command is accepted when valid & ready
//   cmd_op     2'b00 hold, 2'b01 reset, 2'b10 set, 2'b11 toggle ({J,K})
//   cmd_sel    per-cell target mask
//   cmd_rep    extra edges; the command is driven for cmd_rep+1 cycles
//   q_in       feedback from the JK bank q outputs
//   j, k       registered per-cell drive to the bank
//   busy       high whenever the sequencer is not idle
//   done       one-cycle pulse in the completion cycle
//   q_snap     bank state captured at completion
//   err        sticky completion mismatch (check build only, else 0)
// -----------------------------------------------------------------------------
module jk_cmd_scheduler #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [N-1:0]     cmd_sel,
  input  logic [CNT_W-1:0] cmd_rep,
  input  logic [N-1:0]     q_in,
  output logic [N-1:0]     j,
  output logic [N-1:0]     k,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     q_snap,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0]       op;
    logic [N-1:0]     sel;
    logic [CNT_W-1:0] rep;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, DONE} state_t;

  state_t           state, state_nxt;
  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, push, pop;
  logic [CNT_W-1:0] cnt;

  // ---------------------------------------------------------------------------
  // Command FIFO. The pointers carry one extra bit so full and empty can be
  // told apart when the index bits are equal.
  // ---------------------------------------------------------------------------
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset. Flushing the pointers is enough,
  // because an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{op: cmd_op, sel: cmd_sel, rep: cmd_rep};
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaults come first so every path assigns every output, which keeps
  // this block purely combinational (no latches).
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = ISSUE;
          pop       = 1'b1;
        end
      end
      ISSUE:  if (cnt == '0) state_nxt = SETTLE;
      SETTLE: state_nxt = DONE;
      DONE: begin
        if (!empty) begin
          state_nxt = ISSUE;
          pop       = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // ---------------------------------------------------------------------------
  // Drive and snapshot datapath. j/k load at the pop edge and hold while the
  // counter runs down. They clear on the edge that leaves ISSUE. The snapshot
  // is taken on the edge into DONE so it appears alongside done.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j      <= '0;
      k      <= '0;
      cnt    <= '0;
      q_snap <= '0;
    end else begin
      if (pop) begin
        j   <= head.op[1] ? head.sel : '0;
        k   <= head.op[0] ? head.sel : '0;
        cnt <= head.rep;
      end else if (state == ISSUE && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        j <= '0;
        k <= '0;
      end
      if (state == SETTLE) q_snap <= q_in;
    end
  end

`ifdef JK_CMD_SCHED_CHECK_EN
  // ---------------------------------------------------------------------------
  // Completion checker: remember the pre-command bank state and the command.
  // Judge q_in at the edge into DONE, so err rises together with done.
  // ---------------------------------------------------------------------------
  logic [N-1:0] pre, cur_sel, expect_q;
  logic [1:0]   cur_op;
  logic         cur_flip;   // odd number of drive cycles (rep even)

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre      <= '0;
      cur_sel  <= '0;
      cur_op   <= '0;
      cur_flip <= 1'b0;
    end else if (pop) begin
      pre      <= q_in;
      cur_sel  <= head.sel;
      cur_op   <= head.op;
      cur_flip <= ~head.rep[0];
    end
  end

  always_comb begin
    expect_q = pre;
    case (cur_op)
      2'b01:   expect_q = pre & ~cur_sel;
      2'b10:   expect_q = pre | cur_sel;
      2'b11:   expect_q = pre ^ (cur_sel & {N{cur_flip}});
      default: expect_q = pre;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     err <= 1'b0;
    else if (state == SETTLE && q_in != expect_q) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_jk_cmd_scheduler
//
// Drives jk_cmd_scheduler against a behavioural JK bank with an optional
// stuck-at-0 mask on the feedback.
//
// A command-level model runs alongside the DUT. It holds a queue of accepted
// commands, each with its start edge and length. The result of a command is
// computed from its semantics when the command is popped, so the model never
// steps the JK cells cycle by cycle. A compare process on every falling edge
// checks all DUT outputs against the model. Directed tests add literal,
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_jk_cmd_scheduler;
  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [N-1:0]     cmd_sel = '0;
  logic [CNT_W-1:0] cmd_rep = '0;
  logic [N-1:0]     q_in, j, k, q_snap;
  logic             busy, done, err;

  logic [N-1:0]     bank_q;
  logic [N-1:0]     stuck = '0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  jk_cmd_scheduler #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_rep(cmd_rep),
    .q_in(q_in), .j(j), .k(k),
    .busy(busy), .done(done), .q_snap(q_snap), .err(err)
  );

  // Environment: the JK bank itself, reset together with the scheduler.
  always @(posedge clk or posedge rst) begin
    if (rst) bank_q <= '0;
    else begin
      for (int i = 0; i < N; i++) begin
        case ({j[i], k[i]})
          2'b01:   bank_q[i] <= 1'b0;
          2'b10:   bank_q[i] <= 1'b1;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
      end
    end
  end
  assign q_in = bank_q & ~stuck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Command-level reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] sel;
    int           rep;
  } cmd_s;

  cmd_s         pend[$];
  cmd_s         cur;
  bit           cur_act, cur_err, err_m;
  int           cur_start, ecount;
  logic [N-1:0] mq, cur_snap, snap_m, pre_m;

  // Bank value after a command; toggle flips only for an odd edge count.
  function automatic logic [N-1:0] apply_cmd(input logic [1:0] op, input logic [N-1:0] sel,
                                             input int rep, input logic [N-1:0] q);
    case (op)
      2'b10:   return q | sel;
      2'b01:   return q & ~sel;
      2'b11:   return (((rep + 1) % 2) == 1) ? (q ^ sel) : q;
      default: return q;
    endcase
  endfunction

  task automatic model_reset();
    pend.delete();
    cur_act   = 0;
    cur_err   = 0;
    err_m     = 0;
    cur_start = 0;
    ecount    = 0;
    mq        = '0;
    snap_m    = '0;
    cur_snap  = '0;
    pre_m     = '0;
  endtask

  // Advance the model across the next rising edge, given the current inputs.
  task automatic model_step(input int off);
    bit acc;
    acc = cmd_valid && (pend.size() < DEPTH);
    if (cur_act && off == cur.rep + 1) begin
      snap_m = cur_snap;
`ifdef JK_CMD_SCHED_CHECK_EN
      err_m = err_m | cur_err;
`endif
    end
    if (!cur_act || off == cur.rep + 2) begin
      cur_act = 0;
      if (pend.size() > 0) begin
        cur       = pend.pop_front();
        cur_act   = 1;
        cur_start = ecount + 1;
        pre_m     = mq & ~stuck;
        mq        = apply_cmd(cur.op, cur.sel, cur.rep, mq);
        cur_snap  = mq & ~stuck;
        cur_err   = (apply_cmd(cur.op, cur.sel, cur.rep, pre_m) != cur_snap);
      end
    end
    if (acc) pend.push_back('{cmd_op, cmd_sel, int'(cmd_rep)});
    ecount++;
  endtask

  // Compare process: outputs are stable mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    logic [N-1:0] ej, ek;
    logic         eb, ed;
    int           off;
    if (rst) model_reset();
    ej  = '0;
    ek  = '0;
    eb  = 1'b0;
    ed  = 1'b0;
    off = ecount - cur_start;
    if (cur_act) begin
      eb = 1'b1;
      if (off <= cur.rep) begin
        ej = cur.op[1] ? cur.sel : '0;
        ek = cur.op[0] ? cur.sel : '0;
      end else if (off == cur.rep + 2) begin
        ed = 1'b1;
      end
    end
    check("cyc_j", j, ej);
    check("cyc_k", k, ek);
    check("cyc_busy", busy, eb);
    check("cyc_done", done, ed);
    check("cyc_q_snap", q_snap, snap_m);
    check("cyc_err", err, err_m);
    check("cyc_cmd_ready", cmd_ready, pend.size() < DEPTH);
    if (!rst) model_step(off);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 2 time units after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic push(input logic [1:0] op, input logic [N-1:0] sel, input logic [CNT_W-1:0] rep);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = sel;
    cmd_rep   = rep;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #2;
    end
    cmd_valid = 1'b0;
    check("push_accepted", ok, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (busy && n < 200);
    check("idle_timeout", busy, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic exp_err;
`ifdef JK_CMD_SCHED_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    check("rst_j", j, 0);
    check("rst_k", k, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q_snap", q_snap, 0);
    check("rst_err", err, 0);
    check("rst_cmd_ready", cmd_ready, 1);

    // Set cells 0 and 2 for a single edge.
    push(2'b10, 4'b0101, 4'd0);
    @(posedge clk); #2;
    check("set_j", j, 4'b0101);
    check("set_k", k, 4'b0000);
    check("set_busy", busy, 1);
    @(posedge clk); #2;
    check("set_j_settle", j, 4'b0000);
    @(posedge clk); #2;
    check("set_done", done, 1);
    check("set_q_snap", q_snap, 4'b0101);
    @(posedge clk); #2;
    check("set_done_end", done, 0);
    check("set_idle", busy, 0);

    // Three toggle edges on all cells: 0101 -> 1010.
    push(2'b11, 4'b1111, 4'd2);
    wait_idle();
    check("tog_q_snap", q_snap, 4'b1010);
    check("tog_err", err, 0);

    // Maximum repeat: 16 toggle edges on cell 0 leave it unchanged.
    push(2'b11, 4'b0001, 4'd15);
    wait_idle();
    check("maxrep_q_snap", q_snap, 4'b1010);

    // Long first command, then five more: the FIFO fills and the last one waits.
    push(2'b10, 4'b0011, 4'd5);
    push(2'b11, 4'b0110, 4'd1);
    push(2'b00, 4'b1111, 4'd0);
    push(2'b01, 4'b1000, 4'd2);
    push(2'b11, 4'b1001, 4'd3);
    check("full_cmd_ready", cmd_ready, 0);
    push(2'b10, 4'b0100, 4'd0);
    wait_idle();
    check("burst_q_snap", q_snap, 4'b0111);

    // Empty mask: no drive, completion still reported after 4 cycles.
    push(2'b01, 4'b0000, 4'd1);
    @(posedge clk); #2;
    check("nosel_j", j, 0);
    check("nosel_k", k, 0);
    check("nosel_busy", busy, 1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("nosel_done_early", done, 0);
    @(posedge clk); #2;
    check("nosel_done", done, 1);
    check("nosel_q_snap", q_snap, 4'b0111);
    wait_idle();

    // Reset in the middle of a long toggle, with a second command queued.
    push(2'b11, 4'b1111, 4'd7);
    push(2'b10, 4'b1111, 4'd0);
    @(posedge clk); #2;
    check("mid_j_active", j, 4'b1111);
    rst = 1'b1;
    #1;
    check("mid_rst_j", j, 0);
    check("mid_rst_k", k, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_q_snap", q_snap, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("mid_rst_flushed", busy, 0);

    // Feedback bit 0 stuck low: a set on cell 0 cannot take effect.
    stuck = 4'b0001;
    push(2'b10, 4'b0001, 4'd0);
    wait_idle();
    check("stuck_q_snap", q_snap, 4'b0000);
    check("stuck_err", err, exp_err);
    push(2'b00, 4'b0010, 4'd0);
    wait_idle();
    check("stuck_err_sticky", err, exp_err);
    stuck = 4'b0000;
    pulse_reset();
    check("stuck_err_cleared", err, 0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/jk_cmd_scheduler.md
# jk_cmd_scheduler

Command scheduler that sequences a bank of N JK flip-flop cells. Queues incoming set/reset/toggle/hold commands in a small FIFO and drives per-cell J/K lines for a programmed number of clock edges. After each command it snapshots the bank outputs and pulses `done`. Sits between a host/testbench command source and the JK flip-flop bank, whose `q` outputs are fed back.

## Interface
- `N`, 4: number of JK cells driven.
- `DEPTH`, 4: command FIFO depth; power of 2, ≥2.
- `CNT_W`, 4: width of the repeat count.

- `clk`  in  1  clock; same clock as the JK bank.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept; equals "FIFO not full".
- `cmd_op`  in  2  00 hold, 01 reset, 10 set, 11 toggle (J,K encoding).
- `cmd_sel`  in  N  per-cell target mask.
- `cmd_rep`  in  CNT_W  extra edges; command is driven for `cmd_rep`+1 cycles.
- `q_in`  in  N  feedback from the JK bank `q` outputs.
- `j`, `k`  out  N each  registered drive to the JK bank.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at command completion.
- `q_snap`  out  N  bank state captured at completion.
- `err`  out  1  sticky mismatch flag (see Configuration).

## Operation
- Push: a command is accepted on a rising edge when `cmd_valid` and `cmd_ready` are both high. `cmd_op`, `cmd_sel` and `cmd_rep` are written to the FIFO.
- FSM states and transitions:
  - IDLE → ISSUE: FIFO non-empty. Pops the head entry, loads the repeat counter with `rep`, and captures `q_in` as `pre`.
  - ISSUE: drives `j[i]=op[1]&sel[i]` and `k[i]=op[0]&sel[i]` (unselected cells get 00). Decrements the counter each cycle. Exits to SETTLE when the counter is 0.
  - SETTLE: `j`=`k`=0 for one cycle so the bank's last update is visible on `q_in`.
  - DONE: `q_snap`←`q_in`, `done`=1 for one cycle. Then → ISSUE if the FIFO is non-empty (pop in the same cycle), else → IDLE.
- The FIFO supports push and pop in the same cycle; occupancy is unchanged in that case.
- Full FIFO: `cmd_ready`=0 and pushes are ignored. Empty FIFO: FSM remains in IDLE.
- `cmd_sel`=0: the command still runs its full cycle count with `j`=`k`=0, and `done` still pulses.
- `cmd_rep` at its maximum (2^CNT_W−1) gives 2^CNT_W drive cycles. The counter never wraps.

## Timing
- Reset values: `j`=`k`=0, `q_snap`=0, `done`=0, `busy`=0, `err`=0, `cmd_ready`=1. FIFO is flushed and FSM is in IDLE.
- Accept at edge T → pop at edge T+1 → `j`/`k` valid from T+1 through T+1+rep (rep+1 cycles).
- SETTLE is the next cycle. DONE follows it with `done` and the new `q_snap` visible together.
- Per-command occupancy: rep+3 cycles (ISSUE rep+1, SETTLE 1, DONE 1). Back-to-back commands add no IDLE cycle.
- Reset asserted mid-command: all outputs return to reset values immediately, and the in-flight command and queued commands are discarded. No `done` pulse is produced.

## Configuration
- Macro `JK_CMD_SCHED_CHECK_EN`.
- When defined: the expected value for selected cells is computed in DONE:
  - set → 1
  - reset → 0
  - toggle → `pre` XOR ((rep+1) odd)
  - hold → `pre`
- Unselected cells expect `pre`. Any mismatch with `q_in` sets `err`, which is cleared only by `rst`.
- When undefined: no `pre` register and no comparator; `err` is tied to 0.

## Test plan
- Reset, then push {op=10, sel=4'b0101, rep=0} → `j`=0101, `k`=0000 for exactly 1 cycle; `done` 3 cycles after the pop; `q_snap`=0101.
- Push {op=11, sel=4'b1111, rep=2} starting from q=0101 → 3 toggle cycles; `q_snap`=1010; `err`=0 (with CHECK_EN).
- Push 5 commands back-to-back with DEPTH=4 while the first executes → `cmd_ready` drops when the FIFO is full; all accepted commands complete in order; `done` pulses are rep+3 cycles apart.
- Push {op=01, sel=0, rep=1} → `j`=`k`=0 throughout; `done` still pulses after 4 cycles; `q_snap` unchanged.
- Assert `rst` during ISSUE of {op=11, rep=7} → `j`=`k`=0 and `busy`=0 immediately; FIFO is empty afterwards; no `done` pulse.
- With CHECK_EN, force `q_in` bit 0 stuck at 0, then command set on sel=0001 → `err`=1 at DONE and it stays high until `rst`.
